// File: rtl/adder4b_checker.sv
// Realigns the reference sum to the DUT latency, compares every valid cycle and keeps status, saturating counts and the first mismatch.
// Latency: compare at edge n+1+DELAY for enable sampled at edge n; results visible after that edge. No backpressure; HALT freezes checking.
module adder4b_checker #(
  parameter int DELAY       = 1,
  parameter int CNT_W       = 16,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [4:0]       Ref_Sum,
  input  logic [4:0]       dut_sum,
  input  logic             clear,
  output logic             mismatch,
  output logic             error,
  output logic             pass,
  output logic [CNT_W-1:0] check_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [4:0]       first_dut,
  output logic [4:0]       first_ref,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  typedef struct packed {
    logic       vld;
    logic [4:0] sum;
  } stage_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t     state_q;
  state_t     state_d;
  logic       e_q;
  logic       tap_vld;
  logic [4:0] tap_sum;
  logic       do_cmp;
  logic       cmp_fail;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        e_q <= 1'b0;
    else if (clear) e_q <= 1'b0;
    else            e_q <= enable;
  end

  // Valid bits are flushed by clear so stale reference data never produces a compare.
  generate
    if (DELAY == 0) begin : g_nodly
      assign tap_vld = e_q;
      assign tap_sum = Ref_Sum;
    end else begin : g_dly
      stage_t pipe [DELAY];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DELAY; i++) pipe[i] <= '0;
        end else begin
          pipe[0].vld <= e_q & ~clear;
          pipe[0].sum <= Ref_Sum;
          for (int i = 1; i < DELAY; i++) begin
            pipe[i].vld <= pipe[i-1].vld & ~clear;
            pipe[i].sum <= pipe[i-1].sum;
          end
        end
      end

      assign tap_vld = pipe[DELAY-1].vld;
      assign tap_sum = pipe[DELAY-1].sum;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear)       state_d = IDLE;
    else if (do_cmp) state_d = (cmp_fail && STOP_ON_ERR) ? HALT : RUN;
  end

  // Case inequality so that unknown DUT bits count as a failure in simulation.
  always_comb begin
    do_cmp   = tap_vld && (state_q != HALT) && !clear;
    cmp_fail = (dut_sum !== tap_sum);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch  <= 1'b0;
      error     <= 1'b0;
      pass      <= 1'b0;
      check_cnt <= '0;
      err_cnt   <= '0;
      first_dut <= '0;
      first_ref <= '0;
    end else if (clear) begin
      mismatch  <= 1'b0;
      error     <= 1'b0;
      pass      <= 1'b0;
      check_cnt <= '0;
      err_cnt   <= '0;
      first_dut <= '0;
      first_ref <= '0;
    end else begin
      mismatch <= do_cmp && cmp_fail;
      if (do_cmp) begin
        if (check_cnt != '1) check_cnt <= check_cnt + CNT_ONE;
        pass <= !(error || cmp_fail);
        if (cmp_fail) begin
          if (err_cnt != '1) err_cnt <= err_cnt + CNT_ONE;
          error <= 1'b1;
          if (!error) begin
            first_dut <= dut_sum;
            first_ref <= tap_sum;
          end
        end
      end
    end
  end

  assign state = state_q;

endmodule
